audio_pwm_envelope: RTL and testbench

AUDIO_PWM_ENVELOPE -- requirements
Module: audio_pwm_envelope

---
 rtl/audio_pwm_envelope.sv | 167 ++++++++++++++++
 tb/tb_audio_pwm_envelope.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_pwm_envelope.sv
// Note-driven square-wave tone shaped by a millisecond-tick attack/sustain/release
// envelope, rendered as an 8-bit PWM stream.
module audio_pwm_envelope #(
  parameter int CLK_FRE      = 50_000_000,
  parameter int ATTACK_STEP  = 16,
  parameter int RELEASE_STEP = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       enable,
  input  logic       noteStrobe,
  input  logic [7:0] note,
  input  logic [7:0] velocity,
  input  logic       gate,
  output logic       pwmOut,
  output logic [7:0] envLevel,
  output logic       active
);

  localparam int TICK_DIV = CLK_FRE / 1000;
  localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);
  localparam int NOTE_HZ [0:13] = '{262, 294, 330, 349, 392, 440, 494,
                                    523, 587, 659, 698, 784, 880, 988};

  typedef enum logic [1:0] {ST_IDLE, ST_ATTACK, ST_SUSTAIN, ST_RELEASE} state_t;

  logic [31:0] w_half_tab [0:15];
  logic        w_note_valid;
  logic        w_strobe;
  logic        w_tick;
  logic [8:0]  w_att_sum;
  logic        w_att_done;
  logic        w_rel_done;

  logic [31:0] r_tone_cnt;
  logic [31:0] r_half;
  logic        r_phase;
  logic [31:0] r_presc;
  state_t      r_state;
  logic [7:0]  r_env;
  logic [7:0]  r_target;
  logic        r_active;
  logic [7:0]  r_pwm_cnt;
  logic [7:0]  r_amp;
  logic        r_pwm;

  // Half-period lookup indexed by note code; codes 0 and 15 are rests.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_half
      if (gi >= 1 && gi <= 14) begin : g_note
        assign w_half_tab[gi] = 32'((CLK_FRE / NOTE_HZ[gi-1]) / 2);
      end else begin : g_rest
        assign w_half_tab[gi] = '0;
      end
    end
  endgenerate

  assign w_note_valid = (note >= 8'd1) && (note <= 8'd14);
  assign w_strobe     = enable && noteStrobe;
  assign w_tick       = (r_presc == TICK_LAST);
  assign w_att_sum    = {1'b0, r_env} + 9'(ATTACK_STEP);
  assign w_att_done   = (w_att_sum >= {1'b0, r_target});
  assign w_rel_done   = ({1'b0, r_env} <= 9'(RELEASE_STEP));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tone_cnt <= '0;
      r_half     <= '0;
      r_phase    <= 1'b0;
    end else if (w_strobe && w_note_valid) begin
      r_tone_cnt <= '0;
      r_phase    <= 1'b0;
      r_half     <= w_half_tab[note[3:0]];
    end else if (r_tone_cnt >= r_half) begin
      r_tone_cnt <= '0;
      r_phase    <= ~r_phase;
    end else begin
      r_tone_cnt <= r_tone_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 32'd1;
    end
  end

  // Strobe outranks gate and tick; in ATTACK a low gate outranks the tick.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_IDLE;
      r_env    <= '0;
      r_target <= '0;
      r_active <= 1'b0;
    end else if (!enable) begin
      r_state  <= ST_IDLE;
      r_env    <= '0;
      r_active <= 1'b0;
    end else if (noteStrobe) begin
      if (w_note_valid && (velocity != 8'd0)) begin
        r_target <= velocity;
        r_state  <= ST_ATTACK;
        r_active <= 1'b1;
      end else if (r_state == ST_ATTACK || r_state == ST_SUSTAIN) begin
        r_state  <= ST_RELEASE;
        r_active <= 1'b1;
      end
    end else begin
      case (r_state)
        ST_ATTACK: begin
          if (!gate) begin
            r_state <= ST_RELEASE;
          end else if (w_tick) begin
            if (w_att_done) begin
              r_env   <= r_target;
              r_state <= ST_SUSTAIN;
            end else begin
              r_env <= w_att_sum[7:0];
            end
          end
        end
        ST_SUSTAIN: begin
          if (!gate) r_state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (w_tick) begin
            if (w_rel_done) begin
              r_env    <= '0;
              r_state  <= ST_IDLE;
              r_active <= 1'b0;
            end else begin
              r_env <= r_env - 8'(RELEASE_STEP);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Amplitude only reloads at the PWM wrap so each 256-cycle frame has one duty.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pwm_cnt <= '0;
      r_amp     <= '0;
      r_pwm     <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
      if (!enable) begin
        r_amp <= '0;
      end else if (r_pwm_cnt == 8'hFF) begin
        r_amp <= r_phase ? r_env : 8'd0;
      end
      r_pwm <= enable && (r_pwm_cnt < r_amp);
    end
  end

  assign pwmOut   = r_pwm;
  assign envLevel = r_env;
  assign active   = r_active;

endmodule

// File: tb/tb_audio_pwm_envelope.sv
// Bench for audio_pwm_envelope: directed envelope scenarios plus random strobes,
// checked against a cycle-indexed arithmetic model of the tone, envelope and PWM.
module tb_audio_pwm_envelope;
  localparam int CLK_FRE = 1_000_000;
  localparam int AST     = 16;
  localparam int RST     = 4;
  localparam int TICK    = CLK_FRE / 1000;
  localparam int HZ [0:13] = '{262, 294, 330, 349, 392, 440, 494,
                               523, 587, 659, 698, 784, 880, 988};
  localparam int M_IDLE = 0, M_ATT = 1, M_SUS = 2, M_REL = 3;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       enable = 1'b1;
  logic       noteStrobe = 1'b0;
  logic [7:0] note = 8'd0;
  logic [7:0] velocity = 8'd0;
  logic       gate = 1'b0;
  logic       pwmOut;
  logic [7:0] envLevel;
  logic       active;

  audio_pwm_envelope #(
    .CLK_FRE(CLK_FRE), .ATTACK_STEP(AST), .RELEASE_STEP(RST)
  ) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .noteStrobe(noteStrobe),
    .note(note), .velocity(velocity), .gate(gate),
    .pwmOut(pwmOut), .envLevel(envLevel), .active(active)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int mm = 0;
  bit trace_on = 1'b0;

  // Model state: cycle index since reset release drives tick, phase and PWM position.
  int m_cyc = 0, m_state = M_IDLE, m_env = 0, m_target = 0, m_amp = 0, m_pwm = 0;
  int m_strobe_at = 0, m_half = 0;
  int me, m_phase, m_pcnt, n_state, n_env, n_target, n_amp, n_pwm;
  bit m_tick, m_valid;

  function automatic int half_of(input int n);
    if (n >= 1 && n <= 14) return (CLK_FRE / HZ[n-1]) / 2;
    return 0;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_cyc = 0; m_state = M_IDLE; m_env = 0; m_target = 0;
      m_amp = 0; m_pwm = 0; m_strobe_at = 0; m_half = 0;
    end else begin
      me      = m_cyc + 1;
      m_tick  = ((me % TICK) == 0);
      m_phase = ((me - 1 - m_strobe_at) / (m_half + 1)) % 2;
      m_pcnt  = (me - 1) % 256;
      n_pwm   = (enable && (m_pcnt < m_amp)) ? 1 : 0;
      if (!enable) n_amp = 0;
      else if (m_pcnt == 255) n_amp = (m_phase == 1) ? m_env : 0;
      else n_amp = m_amp;
      n_state = m_state; n_env = m_env; n_target = m_target;
      m_valid = (note >= 8'd1) && (note <= 8'd14);
      if (!enable) begin
        n_state = M_IDLE; n_env = 0;
      end else if (noteStrobe) begin
        if (m_valid && velocity != 8'd0) begin
          n_target = int'(velocity); n_state = M_ATT;
        end else if (m_state == M_ATT || m_state == M_SUS) begin
          n_state = M_REL;
        end
        if (m_valid) begin
          m_strobe_at = me; m_half = half_of(int'(note));
        end
      end else if (m_state == M_ATT) begin
        if (!gate) n_state = M_REL;
        else if (m_tick) begin
          n_env = (m_env + AST < m_target) ? m_env + AST : m_target;
          if (n_env == m_target) n_state = M_SUS;
        end
      end else if (m_state == M_SUS) begin
        if (!gate) n_state = M_REL;
      end else if (m_state == M_REL && m_tick) begin
        n_env = (m_env > RST) ? m_env - RST : 0;
        if (n_env == 0) n_state = M_IDLE;
      end
      m_state = n_state; m_env = n_env; m_target = n_target;
      m_amp = n_amp; m_pwm = n_pwm; m_cyc = me;
    end
  end

  always @(negedge clk) begin
    if (trace_on && rstn) begin
      if (int'(envLevel) != m_env || int'(active) != ((m_state != M_IDLE) ? 1 : 0) ||
          int'(pwmOut) != m_pwm)
        mm++;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_env"}, int'(envLevel), m_env);
    chk({tag, "_act"}, int'(active), (m_state != M_IDLE) ? 1 : 0);
    chk({tag, "_pwm"}, int'(pwmOut), m_pwm);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [7:0] n, input logic [7:0] v);
    note = n; velocity = v; noteStrobe = 1'b1;
    $display("strobe note=%0d vel=%0d gate=%0d en=%0d t=%0t", n, v, gate, enable, $time);
    @(negedge clk);
    noteStrobe = 1'b0;
  endtask

  task automatic next_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((m_cyc % TICK) != 0 && n <= TICK + 1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi;
    int n;
    cyc(3);
    chk("rst_pwm", int'(pwmOut), 0);
    chk("rst_env", int'(envLevel), 0);
    chk("rst_act", int'(active), 0);
    rstn = 1'b1;
    trace_on = 1'b1;

    // Attack to 128 on note 6
    cyc($urandom_range(1, 200));
    gate = 1'b1;
    strobe(8'd6, 8'd128);
    chk("s1_start_env", int'(envLevel), 0);
    chk("s1_start_act", int'(active), 1);
    for (int k = 1; k <= 8; k++) begin
      next_tick();
      chk($sformatf("s1_tick%0d", k), int'(envLevel), 16 * k);
    end
    chk_model("s1_sus");

    // Climb to 250, then saturate at 255
    strobe(8'd6, 8'd250);
    for (int k = 1; k <= 8; k++) begin
      next_tick();
      chk($sformatf("s2_tick%0d", k), int'(envLevel), (128 + 16 * k > 250) ? 250 : 128 + 16 * k);
    end
    strobe(8'd6, 8'd255);
    next_tick();
    chk("s2_sat255", int'(envLevel), 255);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((m_cyc % 256) == 0 && m_amp == 255) && n < 5000);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      hi += int'(pwmOut);
    end
    chk("s2_duty255", hi, 255);
    chk("s2_trace", mm, 0);

    // Back to 128, then full release
    strobe(8'd6, 8'd128);
    next_tick();
    chk("s3_clamp128", int'(envLevel), 128);
    gate = 1'b0;
    @(negedge clk);
    chk("s3_gate_env", int'(envLevel), 128);
    for (int k = 1; k <= 32; k++) begin
      next_tick();
      chk($sformatf("s3_rel%0d", k), int'(envLevel), 128 - 4 * k);
      if (k >= 31) chk($sformatf("s3_act%0d", k), int'(active), (k < 32) ? 1 : 0);
    end

    // Retrigger during release at 100
    gate = 1'b1;
    strobe(8'd6, 8'd112);
    for (int k = 1; k <= 7; k++) next_tick();
    chk("s4_peak", int'(envLevel), 112);
    gate = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      next_tick();
      chk($sformatf("s4_rel%0d", k), int'(envLevel), 112 - 4 * k);
    end
    gate = 1'b1;
    strobe(8'd10, 8'd40);
    chk("s4_keep100", int'(envLevel), 100);
    chk("s4_act", int'(active), 1);
    next_tick();
    chk("s4_clamp40", int'(envLevel), 40);
    next_tick();
    chk("s4_hold40", int'(envLevel), 40);

    // Rest note releases; reset mid-attack; velocity 0 from idle
    strobe(8'd0, 8'd90);
    chk("s5_rest_env", int'(envLevel), 40);
    chk("s5_rest_act", int'(active), 1);
    next_tick();
    chk("s5_rest_dec", int'(envLevel), 36);
    strobe(8'd6, 8'd200);
    cyc($urandom_range(10, 300));
    chk_model("s5_att");
    #2 rstn = 1'b0;
    #1;
    chk("s5_rst_pwm", int'(pwmOut), 0);
    chk("s5_rst_env", int'(envLevel), 0);
    chk("s5_rst_act", int'(active), 0);
    cyc(3);
    rstn = 1'b1;
    cyc(5);
    chk("s5_fresh_act", int'(active), 0);
    strobe(8'd6, 8'd0);
    chk("s5_v0_act", int'(active), 0);
    hi = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      hi += int'(pwmOut);
    end
    chk("s5_v0_pwm", hi, 0);

    // Enable low in sustain
    strobe(8'd3, 8'd64);
    for (int k = 1; k <= 4; k++) next_tick();
    chk("s6_sus64", int'(envLevel), 64);
    cyc($urandom_range(300, 800));
    enable = 1'b0;
    @(negedge clk);
    chk("s6_dis_pwm", int'(pwmOut), 0);
    chk("s6_dis_env", int'(envLevel), 0);
    chk("s6_dis_act", int'(active), 0);
    strobe(8'd5, 8'd99);
    chk("s6_ign_act", int'(active), 0);
    enable = 1'b1;
    @(negedge clk);
    chk("s6_en_act", int'(active), 0);
    chk("s6_trace", mm, 0);

    // Random strobes against the model
    for (int i = 0; i < 12; i++) begin
      enable = ($urandom_range(0, 7) != 0);
      gate = 1'($urandom_range(0, 1));
      strobe(8'($urandom_range(0, 16)),
             ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255)));
      cyc($urandom_range(20, 400));
      chk_model($sformatf("rnd%0d", i));
    end
    enable = 1'b1;
    cyc(4);
    chk("final_trace", mm, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
